// File: rtl/if_id_buffer_pkg.sv
// if_id_pkg: shared constants, state encoding and two-word decode for the IF/ID boundary
package if_id_pkg;
  localparam logic [15:0] NOP = 16'h0000;
  localparam int OP_W = 5;
  localparam logic [1:0] TWO_PFX = 2'b11;
  typedef enum logic {NORMAL, WAIT_IMM} state_t;
  function automatic logic is_two_word(input logic [OP_W-1:0] op);
    return op[OP_W-1 -: 2] == TWO_PFX;
  endfunction
endpackage

// File: rtl/if_id_buffer_pipe_reg.sv
// pipe_reg: width-parameterised register with sync active-low reset, sync clear and enable
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // reset and clear zero the stage; enable loads a new value
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: IF/ID pipeline register that assembles two-word instructions and applies stall/flush
module if_id_buffer
  import if_id_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  instr_i,
  input  logic [W-1:0]  imm_i,
  input  logic [AW-1:0] pc_i,
  input  logic [AW-1:0] pc_1_i,
  input  logic          stall,
  input  logic          flush,
  output logic [W-1:0]  instr_o,
  output logic [W-1:0]  imm_o,
  output logic [AW-1:0] pc_o,
  output logic [AW-1:0] pc_1_o,
  output logic          valid_o,
  output logic          busy_o
);
  localparam int PW = 2*W + 2*AW + 1;
  state_t state;
  logic [OP_W-1:0] op;
  logic two, nop;
  logic [W-1:0] buf_instr;
  logic [AW-1:0] buf_pc;
  logic [PW-1:0] pkt_d, pkt_q;
  assign op = instr_i[W-1 -: OP_W];
  assign two = is_two_word(op);
  assign nop = op == '0;
  // packet for decode: completed two-word pair, bubble while the first word waits, or a one-word/NOP fetch
  always_comb
    pkt_d = state == WAIT_IMM ? {buf_instr, imm_i, buf_pc, pc_1_i, 1'b1}
          : two ? {W'(NOP), {(PW-W){1'b0}}}
          : nop ? {W'(NOP), {W{1'b0}}, pc_i, pc_1_i, 1'b0}
          : {instr_i, {W{1'b0}}, pc_i, pc_1_i, 1'b1};
  // NORMAL -> WAIT_IMM on a first word; flush always returns to NORMAL, stall holds
  always_ff @(posedge clk)
    if (!rst) state <= NORMAL;
    else if (flush) state <= NORMAL;
    else if (!stall) state <= (state == NORMAL && two) ? WAIT_IMM : NORMAL;
  pipe_reg #(.WIDTH(PW)) u_out (
    .clk(clk), .rst(rst), .en(!stall), .clr(flush), .d(pkt_d), .q(pkt_q)
  );
  pipe_reg #(.WIDTH(W + AW)) u_buf (
    .clk(clk), .rst(rst), .en(!stall && state == NORMAL && two), .clr(flush),
    .d({instr_i, pc_i}), .q({buf_instr, buf_pc})
  );
  assign {instr_o, imm_o, pc_o, pc_1_o, valid_o} = pkt_q;
  assign busy_o = state == WAIT_IMM;
endmodule
